// File: rtl/pipe_pkg.sv
// Shared types for the stall-only pipeline control: FSM encoding, register-zero
// constant and the shadow-slot record that tracks in-flight destinations.
package pipe_pkg;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
  } shadow_slot_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against the EX/MEM/WB shadow slots.
// The WB slot is ignored when the register file writes in the first half-cycle.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int WB_BYPASS = 1
) (
  input  logic [4:0]   src,
  input  shadow_slot_t ex_slot,
  input  shadow_slot_t mem_slot,
  input  shadow_slot_t wb_slot,
  output logic         hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_slot.v  && (ex_slot.dst  == src);
  assign mem_hit = mem_slot.v && (mem_slot.dst == src);
  assign wb_hit  = (WB_BYPASS == 0) && wb_slot.v && (wb_slot.dst == src);
  assign hit     = ex_hit || mem_hit || wb_hit;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage stall-only pipeline: RAW interlock,
// fixed branch fetch-freeze and a saturating stall-cycle counter.
//
// Handshake: there is no valid/ready pair here; ext_stall is an absolute hold
// (every stage and this block's state freeze), and pc_en/ifid_en are enables
// that the datapath samples on the same clk edge as this block's state.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic [4:0]       id_wdst,
  input  logic             id_branch,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             br_release,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [0:0]       dbg_state
);

  localparam logic [2:0] PEN_LOAD = 3'(BR_PENALTY - 1);

  logic [0:0]   state, state_nx;
  logic [2:0]   pen_cnt, pen_nx;
  shadow_slot_t ex_s, mem_s, wb_s, issue_s;
  logic         rs_hit, rt_hit, hazard;

  hazard_match #(.WB_BYPASS(WB_BYPASS)) u_match_rs (
    .src(id_rs), .ex_slot(ex_s), .mem_slot(mem_s), .wb_slot(wb_s), .hit(rs_hit)
  );

  hazard_match #(.WB_BYPASS(WB_BYPASS)) u_match_rt (
    .src(id_rt), .ex_slot(ex_s), .mem_slot(mem_s), .wb_slot(wb_s), .hit(rt_hit)
  );

  assign hazard = id_valid &&
                  ((id_use_rs && (id_rs != REG_ZERO) && rs_hit) ||
                   (id_use_rt && (id_rt != REG_ZERO) && rt_hit));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    br_release  = 1'b0;
    state_nx    = state;
    pen_nx      = pen_cnt;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nx    = ST_RUN;
      pen_nx      = 3'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ext_stall) begin
            // ID/EX is held by ext_stall in the datapath, so no bubble here
          end else if (hazard) begin
            idex_bubble = 1'b1;
          end else if (id_valid && id_branch) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            pen_nx     = PEN_LOAD;
            state_nx   = ST_BR_WAIT;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        ST_BR_WAIT: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (!ext_stall) begin
            ifid_en = 1'b1;
            if (pen_cnt == 3'd0) begin
              pc_en      = 1'b1;
              br_release = 1'b1;
              state_nx   = ST_RUN;
            end else begin
              pen_nx = pen_cnt - 3'd1;
            end
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  // A bubbled ID instruction never reaches EX, so it must not occupy a slot.
  always_comb begin
    issue_s.v   = id_valid && id_wreg && (id_wdst != REG_ZERO) && !idex_bubble;
    issue_s.dst = id_wdst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pen_cnt   <= 3'd0;
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nx;
      pen_cnt <= pen_nx;
      if (!ext_stall) begin
        ex_s  <= issue_s;
        mem_s <= ex_s;
        wb_s  <= mem_s;
      end
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: two instances share stimulus, one with the
// WB bypass and a wide counter, one checking the WB slot with a 4-bit counter.
module tb_pipe_stall_ctrl;
  import pipe_pkg::*;

  logic       clk;
  logic       rst;
  logic       ext_stall;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wdst;
  logic       id_use_rs, id_use_rt, id_wreg, id_branch;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble, br_release;
  logic [31:0] stall_cnt;
  logic [0:0]  dbg_state;

  logic        nb_pc_en, nb_ifid_en, nb_ifid_flush, nb_idex_bubble, nb_br_release;
  logic [3:0]  nb_stall_cnt;
  logic [0:0]  nb_dbg_state;

  int checks;
  int failures;

  pipe_stall_ctrl #(.BR_PENALTY(2), .WB_BYPASS(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_wdst(id_wdst), .id_branch(id_branch),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .br_release(br_release),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipe_stall_ctrl #(.BR_PENALTY(2), .WB_BYPASS(0), .CNT_W(4)) dut_nb (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_wdst(id_wdst), .id_branch(id_branch),
    .pc_en(nb_pc_en), .ifid_en(nb_ifid_en), .ifid_flush(nb_ifid_flush),
    .idex_bubble(nb_idex_bubble), .br_release(nb_br_release),
    .stall_cnt(nb_stall_cnt), .dbg_state(nb_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // outputs are sampled on the falling edge, inputs change just after the rising edge
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wreg = 1'b0; id_wdst = 5'd0; id_branch = 1'b0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                             input logic urt, input logic wr, input logic [4:0] wd,
                             input logic br);
    id_valid = 1'b1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wreg = wr; id_wdst = wd; id_branch = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ext_stall = 1'b0;
    drive_idle();
    adv();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ext_stall = 1'b0;
    drive_idle();

    // reset values while rst is held
    settle();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_ifid_en", ifid_en, 0);
    chk("rst_ifid_flush", ifid_flush, 1);
    chk("rst_idex_bubble", idex_bubble, 1);
    chk("rst_br_release", br_release, 0);
    adv();
    adv();
    rst = 1'b0;
    settle();
    chk("post_rst_cnt", stall_cnt, 0);
    chk("post_rst_state", dbg_state, ST_RUN);

    // 1: independent ALU stream
    adv();
    for (int i = 0; i < 4; i++) begin
      drive_instr(5'(20 + i), 1'b1, 5'(24 + i), 1'b1, 1'b1, 5'(1 + i), 1'b0);
      settle();
      chk("alu_pc_en", pc_en, 1);
      chk("alu_bubble", idex_bubble, 0);
      chk("alu_nb_pc_en", nb_pc_en, 1);
      adv();
    end
    drive_idle();
    settle();
    chk("alu_cnt", stall_cnt, 0);
    chk("alu_nb_cnt", nb_stall_cnt, 0);

    // 2/3: RAW on $5, two stalls with WB bypass, three without
    do_reset();
    drive_instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b1, 5'd5, 1'b0);
    settle();
    chk("raw_writer_pc_en", pc_en, 1);
    adv();
    drive_instr(5'd5, 1'b1, 5'd22, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("raw_pc_en", pc_en, (k >= 2) ? 1 : 0);
      chk("raw_bubble", idex_bubble, (k < 2) ? 1 : 0);
      chk("raw_nb_pc_en", nb_pc_en, (k >= 3) ? 1 : 0);
      chk("raw_nb_bubble", nb_idex_bubble, (k < 3) ? 1 : 0);
      adv();
    end
    drive_idle();
    settle();
    chk("raw_cnt", stall_cnt, 2);
    chk("raw_nb_cnt", nb_stall_cnt, 3);

    // 3: $0 never creates a hazard
    do_reset();
    drive_instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b1, 5'd0, 1'b0);
    adv();
    drive_instr(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    settle();
    chk("zero_pc_en", pc_en, 1);
    chk("zero_nb_pc_en", nb_pc_en, 1);
    adv();
    drive_idle();
    settle();
    chk("zero_cnt", stall_cnt, 0);

    // use_rs masking, then rt hazard against MEM slot
    do_reset();
    drive_instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b1, 5'd8, 1'b0);
    adv();
    drive_instr(5'd8, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    settle();
    chk("mask_rs_pc_en", pc_en, 1);
    adv();
    drive_instr(5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
    settle();
    chk("rt_mem_pc_en", pc_en, 0);
    chk("rt_mem_bubble", idex_bubble, 1);
    adv();

    // ext_stall in RUN freezes the shadow pipe: the hazard is still two cycles after
    do_reset();
    drive_instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b1, 5'd9, 1'b0);
    adv();
    drive_instr(5'd9, 1'b1, 5'd22, 1'b1, 1'b0, 5'd0, 1'b0);
    ext_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ext_pc_en", pc_en, 0);
      chk("ext_ifid_en", ifid_en, 0);
      chk("ext_bubble", idex_bubble, 0);
      adv();
    end
    ext_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ext_raw_pc_en", pc_en, (k >= 2) ? 1 : 0);
      adv();
    end
    drive_idle();
    settle();
    chk("ext_raw_cnt", stall_cnt, 5);

    // 4: branch with penalty 2
    do_reset();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    settle();
    chk("br_issue_pc_en", pc_en, 0);
    chk("br_issue_ifid_en", ifid_en, 1);
    chk("br_issue_flush", ifid_flush, 1);
    chk("br_issue_bubble", idex_bubble, 0);
    adv();
    drive_idle();
    settle();
    chk("br_w1_state", dbg_state, ST_BR_WAIT);
    chk("br_w1_pc_en", pc_en, 0);
    chk("br_w1_release", br_release, 0);
    chk("br_w1_bubble", idex_bubble, 1);
    adv();
    settle();
    chk("br_w2_pc_en", pc_en, 1);
    chk("br_w2_release", br_release, 1);
    adv();
    settle();
    chk("br_after_state", dbg_state, ST_RUN);
    chk("br_after_release", br_release, 0);
    chk("br_cnt", stall_cnt, 2);

    // 5: ext_stall for 3 cycles while counter=1 delays release by 3
    do_reset();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    adv();
    drive_idle();
    ext_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("brx_pc_en", pc_en, 0);
      chk("brx_ifid_en", ifid_en, 0);
      chk("brx_release", br_release, 0);
      chk("brx_state", dbg_state, ST_BR_WAIT);
      adv();
    end
    ext_stall = 1'b0;
    settle();
    chk("brx_w1_release", br_release, 0);
    chk("brx_w1_pc_en", pc_en, 0);
    adv();
    settle();
    chk("brx_w2_release", br_release, 1);
    adv();
    settle();
    chk("brx_cnt", stall_cnt, 5);

    // 6: reset mid-BR_WAIT
    do_reset();
    drive_instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1);
    adv();
    drive_idle();
    rst = 1'b1;
    settle();
    chk("rstbr_pc_en", pc_en, 0);
    chk("rstbr_release", br_release, 0);
    adv();
    rst = 1'b0;
    settle();
    chk("rstbr_state", dbg_state, ST_RUN);
    chk("rstbr_pc_en_after", pc_en, 1);
    chk("rstbr_cnt", stall_cnt, 0);

    // 6: reset mid-hazard, the stalled reader then issues at once
    do_reset();
    drive_instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b1, 5'd5, 1'b0);
    adv();
    drive_instr(5'd5, 1'b1, 5'd22, 1'b1, 1'b0, 5'd0, 1'b0);
    settle();
    chk("rsthz_stall", pc_en, 0);
    adv();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    chk("rsthz_pc_en", pc_en, 1);
    chk("rsthz_nb_pc_en", nb_pc_en, 1);
    chk("rsthz_cnt", stall_cnt, 0);
    adv();

    // counter saturation on the 4-bit instance
    do_reset();
    ext_stall = 1'b1;
    for (int k = 0; k < 20; k++) adv();
    ext_stall = 1'b0;
    settle();
    chk("sat_nb_cnt", nb_stall_cnt, 15);
    chk("sat_cnt", stall_cnt, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
